// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage controller: turns LDR/STR/LDB/STB/LDI/STI into data-cache requests and stalls until done.
// Optional MEM_ALIGN_TRAP_EN: misaligned word accesses skip the cache and raise align_fault.
`timescale 1ns/1ps
module mem_stage_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_indirect,
  input  logic             mem_byte,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] store_data,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             dmem_resp,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [WIDTH-1:0] dmem_address,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [1:0]       dmem_byte_enable,
  output logic             stall,
  output logic [WIDTH-1:0] wb_data,
  output logic             align_fault
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] ptr;
  logic [WIDTH-1:0] result;
  logic             fault;

  logic mem_op;
  logic word_acc1;
  logic trap1;
  logic trap2;

  function automatic logic signed [WIDTH-1:0] sext_byte(input logic signed [7:0] b);
    return WIDTH'(b);
  endfunction

  function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] a);
    return {a[WIDTH-1:1], 1'b0};
  endfunction

  assign mem_op    = in_valid & (mem_read | mem_write);
  // Indirect accesses are always word-sized regardless of mem_byte.
  assign word_acc1 = mem_indirect | ~mem_byte;

`ifdef MEM_ALIGN_TRAP_EN
  assign trap1       = word_acc1 & address[0];
  assign trap2       = dmem_rdata[0];
  assign align_fault = fault & (state == DONE);
`else
  assign trap1       = 1'b0;
  assign trap2       = 1'b0;
  assign align_fault = 1'b0;
`endif

  // State and latches: pointer from first indirect access, load result, fault flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      result <= '0;
      fault  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          fault <= 1'b0;
          if (mem_op) begin
            if (trap1) begin
              fault  <= 1'b1;
              result <= '0;
              state  <= DONE;
            end else begin
              state <= ACC1;
            end
          end
        end
        ACC1: begin
          if (dmem_resp) begin
            if (mem_indirect) begin
              ptr <= dmem_rdata;
              if (trap2) begin
                fault  <= 1'b1;
                result <= '0;
                state  <= DONE;
              end else begin
                state <= ACC2;
              end
            end else begin
              if (mem_read) begin
                if (mem_byte)
                  result <= sext_byte(address[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]);
                else
                  result <= dmem_rdata;
              end
              state <= DONE;
            end
          end
        end
        ACC2: begin
          if (dmem_resp) begin
            if (mem_read)
              result <= dmem_rdata;
            state <= DONE;
          end
        end
        DONE: begin
          fault <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Request and write-back decode from the current state
  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = '0;
    dmem_wdata       = '0;
    dmem_byte_enable = 2'b11;
    stall            = 1'b0;
    wb_data          = alu_out;
    unique case (state)
      IDLE: begin
        stall = mem_op;
      end
      ACC1: begin
        stall = 1'b1;
        if (mem_read | mem_indirect)
          dmem_read = 1'b1;
        else
          dmem_write = 1'b1;
        if (word_acc1) begin
          dmem_address     = word_align(address);
          dmem_wdata       = store_data;
          dmem_byte_enable = 2'b11;
        end else begin
          dmem_address     = address;
          dmem_wdata       = {(WIDTH/8){store_data[7:0]}};
          dmem_byte_enable = address[0] ? 2'b10 : 2'b01;
        end
      end
      ACC2: begin
        stall        = 1'b1;
        dmem_address = word_align(ptr);
        dmem_wdata   = store_data;
        if (mem_read)
          dmem_read = 1'b1;
        else
          dmem_write = 1'b1;
      end
      DONE: begin
        if (fault)
          wb_data = '0;
        else if (mem_read)
          wb_data = result;
        else
          wb_data = alu_out;
      end
    endcase
  end

  a_rd_wr_excl: assert property (@(posedge clk) disable iff (reset) !(dmem_read && dmem_write));

endmodule
